// File: rtl/bbox_pkg.sv
// Shared types and constants for the triangle bounding-box clip unit.
// Covers the FSM states, fp16 field layout and triangle word offsets.
package bbox_pkg;

    typedef enum logic [1:0] {IDLE, CONV, CLIP, OUT} state_t;

    localparam int FP16_SIGN_BIT = 15;
    localparam int FP16_EXP_MSB  = 14;
    localparam int FP16_EXP_LSB  = 10;
    localparam int FP16_MAN_MSB  = 9;
    localparam int FP16_MAN_W    = 10;
    localparam int FP16_BIAS     = 15;
    // Exponent at which the 11-bit significand is an exact integer
    localparam logic [4:0] FP16_INT_EXP = 5'(FP16_BIAS + FP16_MAN_W);

    localparam int TRI_W    = 144;
    localparam int V0_X_LSB = 128;
    localparam int V0_Y_LSB = 112;
    localparam int V1_X_LSB = 80;
    localparam int V1_Y_LSB = 64;
    localparam int V2_X_LSB = 32;
    localparam int V2_Y_LSB = 16;

    // Even steps are x coordinates, odd steps are y coordinates
    function automatic logic [7:0] coord_lsb(input logic [2:0] step);
        case (step)
            3'd0:    return 8'(V0_X_LSB);
            3'd1:    return 8'(V0_Y_LSB);
            3'd2:    return 8'(V1_X_LSB);
            3'd3:    return 8'(V1_Y_LSB);
            3'd4:    return 8'(V2_X_LSB);
            default: return 8'(V2_Y_LSB);
        endcase
    endfunction

endpackage

// File: rtl/fp16_to_int.sv
// Combinational fp16 to signed integer converter.
// Produces saturated floor and ceil values plus a NaN flag.
module fp16_to_int
    import bbox_pkg::*;
#(
    parameter int COORD_W = 16
) (
    input  logic [15:0]               value,
    output logic signed [COORD_W-1:0] floor_int,
    output logic signed [COORD_W-1:0] ceil_int,
    output logic                      is_nan
);

    localparam logic [32:0] MAX_MAG = (33'd1 << (COORD_W - 1)) - 33'd1;

    logic        sign;
    logic [4:0]  exp_f;
    logic [9:0]  man_f;
    logic [32:0] mant;
    logic [32:0] mag;
    logic [32:0] frac_mask;
    logic [32:0] lo_mag;
    logic [32:0] hi_mag;
    logic [32:0] lo_sat;
    logic [32:0] hi_sat;
    logic        frac;

    assign sign  = value[FP16_SIGN_BIT];
    assign exp_f = value[FP16_EXP_MSB:FP16_EXP_LSB];
    assign man_f = value[FP16_MAN_MSB:0];
    assign mant  = {22'd0, 1'b1, man_f};

    // Magnitude is split into integer part and a sticky "has fraction" bit;
    // subnormals fall out naturally as magnitude 0 with a fraction.
    always_comb begin
        mag       = '0;
        frac      = 1'b0;
        frac_mask = '0;
        is_nan    = 1'b0;
        if (exp_f == 5'd31) begin
            is_nan = (man_f != 10'd0);
            mag    = MAX_MAG;
        end else if (exp_f == 5'd0) begin
            frac = (man_f != 10'd0);
        end else if (exp_f >= FP16_INT_EXP) begin
            mag = mant << (exp_f - FP16_INT_EXP);
        end else begin
            frac_mask = (33'd1 << (FP16_INT_EXP - exp_f)) - 33'd1;
            mag       = mant >> (FP16_INT_EXP - exp_f);
            frac      = |(mant & frac_mask);
        end
        lo_mag    = mag + {32'd0, frac & sign};
        hi_mag    = mag + {32'd0, frac & ~sign};
        lo_sat    = (lo_mag > MAX_MAG) ? MAX_MAG : lo_mag;
        hi_sat    = (hi_mag > MAX_MAG) ? MAX_MAG : hi_mag;
        floor_int = sign ? COORD_W'(-lo_sat) : COORD_W'(lo_sat);
        ceil_int  = sign ? COORD_W'(-hi_sat) : COORD_W'(hi_sat);
    end

endmodule

// File: rtl/bbox_clip_unit.sv
// Triangle bounding box with viewport clipping and optional tile alignment.
// One shared converter walks the six x/y coordinates, then one clip cycle.
module bbox_clip_unit
    import bbox_pkg::*;
#(
    parameter int COORD_W   = 16,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int TILE_LOG2 = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TRI_W-1:0]          triangle,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [COORD_W-1:0] bbox_x_min_int,
    output logic signed [COORD_W-1:0] bbox_x_max_int,
    output logic signed [COORD_W-1:0] bbox_y_min_int,
    output logic signed [COORD_W-1:0] bbox_y_max_int,
    output logic                      culled,
    output logic                      nan_err
);

    localparam logic signed [COORD_W-1:0] MAX_VAL   = {1'b0, {(COORD_W-1){1'b1}}};
    localparam logic signed [COORD_W-1:0] MINUS_ONE = '1;
    localparam logic signed [COORD_W-1:0] X_END     = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] Y_END     = COORD_W'(SCREEN_H);
    localparam logic signed [COORD_W-1:0] X_LIM     = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] Y_LIM     = COORD_W'(SCREEN_H - 1);
    localparam logic signed [COORD_W-1:0] TILE_MASK = COORD_W'((1 << TILE_LOG2) - 1);

    state_t                      state;
    logic [2:0]                  step;
    logic [TRI_W-1:0]            tri_q;
    logic signed [COORD_W-1:0]   x_min_r, x_max_r, y_min_r, y_max_r;
    logic                        nan_r;
    logic [15:0]                 coord;
    logic signed [COORD_W-1:0]   conv_floor, conv_ceil;
    logic                        conv_nan;
    logic signed [COORD_W-1:0]   cx_min, cx_max, cy_min, cy_max;
    logic signed [COORD_W-1:0]   ax_max, ay_max;
    logic                        empty;

    // Mins stop one past the far edge so a box fully off-screen stays empty
    function automatic logic signed [COORD_W-1:0] clip_lo(
        input logic signed [COORD_W-1:0] v, input logic signed [COORD_W-1:0] lim);
        if (v[COORD_W-1]) return '0;
        if (v > lim) return lim;
        return v;
    endfunction

    function automatic logic signed [COORD_W-1:0] clip_hi(
        input logic signed [COORD_W-1:0] v, input logic signed [COORD_W-1:0] lim);
        if (v > lim) return lim;
        if (v < MINUS_ONE) return MINUS_ONE;
        return v;
    endfunction

    assign in_ready = (state == IDLE) && !rst;
    assign coord    = tri_q[coord_lsb(step) +: 16];

    fp16_to_int #(.COORD_W(COORD_W)) u_conv (
        .value     (coord),
        .floor_int (conv_floor),
        .ceil_int  (conv_ceil),
        .is_nan    (conv_nan)
    );

    // Emptiness is judged before tile widening, which only ever grows the box
    always_comb begin
        cx_min = clip_lo(x_min_r, X_END);
        cx_max = clip_hi(x_max_r, X_LIM);
        cy_min = clip_lo(y_min_r, Y_END);
        cy_max = clip_hi(y_max_r, Y_LIM);
        empty  = (cx_min > cx_max) || (cy_min > cy_max);
        ax_max = ((cx_max | TILE_MASK) > X_LIM) ? X_LIM : (cx_max | TILE_MASK);
        ay_max = ((cy_max | TILE_MASK) > Y_LIM) ? Y_LIM : (cy_max | TILE_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            step           <= '0;
            tri_q          <= '0;
            x_min_r        <= MAX_VAL;
            x_max_r        <= -MAX_VAL;
            y_min_r        <= MAX_VAL;
            y_max_r        <= -MAX_VAL;
            nan_r          <= 1'b0;
            out_valid      <= 1'b0;
            bbox_x_min_int <= '0;
            bbox_x_max_int <= '0;
            bbox_y_min_int <= '0;
            bbox_y_max_int <= '0;
            culled         <= 1'b0;
            nan_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tri_q   <= triangle;
                        x_min_r <= MAX_VAL;
                        x_max_r <= -MAX_VAL;
                        y_min_r <= MAX_VAL;
                        y_max_r <= -MAX_VAL;
                        nan_r   <= 1'b0;
                        step    <= '0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    if (!conv_nan) begin
                        if (!step[0]) begin
                            if (conv_floor < x_min_r) x_min_r <= conv_floor;
                            if (conv_ceil > x_max_r) x_max_r <= conv_ceil;
                        end else begin
                            if (conv_floor < y_min_r) y_min_r <= conv_floor;
                            if (conv_ceil > y_max_r) y_max_r <= conv_ceil;
                        end
                    end
                    nan_r <= nan_r | conv_nan;
                    step  <= step + 3'd1;
                    if (step == 3'd5) state <= CLIP;
                end
                CLIP: begin
                    bbox_x_min_int <= cx_min & ~TILE_MASK;
                    bbox_x_max_int <= ax_max;
                    bbox_y_min_int <= cy_min & ~TILE_MASK;
                    bbox_y_max_int <= ay_max;
                    culled         <= nan_r | empty;
                    nan_err        <= nan_r;
                    out_valid      <= 1'b1;
                    state          <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_clip_unit.sv
// Scoreboard bench for bbox_clip_unit: an untiled and a TILE_LOG2=3 instance
// share one stimulus stream; expectations come from a real-number model.
module tb_bbox_clip_unit;

    typedef struct {
        logic signed [15:0] x_min;
        logic signed [15:0] x_max;
        logic signed [15:0] y_min;
        logic signed [15:0] y_max;
        logic               culled;
        logic               nan_err;
        int                 accept_edge;
    } res_t;

    localparam int SW = 640;
    localparam int SH = 480;

    localparam logic [143:0] TRI_BASE = {16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                         16'h4600, 16'h4700, 16'h4800, 16'h4880};
    localparam logic [143:0] TRI_FRAC = {16'h3e00, 16'h4100, 16'h4200, 16'h4400, 16'h4500,
                                         16'h4600, 16'h4700, 16'h4800, 16'h4880};
    localparam logic [143:0] TRI_NEGX = {16'hc200, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                         16'h4600, 16'h4700, 16'h4800, 16'h4880};
    localparam logic [143:0] TRI_OFFX = {16'h6178, 16'h4000, 16'h4200, 16'h6178, 16'h4500,
                                         16'h4600, 16'h6178, 16'h4800, 16'h4880};
    localparam logic [143:0] TRI_NAN  = {16'h3c00, 16'h4000, 16'h4200, 16'h4400, 16'h7e00,
                                         16'h4600, 16'h4700, 16'h4800, 16'h4880};
    localparam logic [143:0] TRI_WIDE = {16'h4880, 16'h4000, 16'h4200, 16'h4d00, 16'h4500,
                                         16'h4600, 16'h4b80, 16'h4800, 16'h4880};
    localparam logic [143:0] TRI_INF  = {16'h7c00, 16'h8001, 16'h4200, 16'h4400, 16'h4500,
                                         16'h4600, 16'h4700, 16'h4800, 16'h4880};

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic [143:0]       triangle;
    logic               out_ready;
    logic               in_ready0, out_valid0, culled0, nan0;
    logic               in_ready1, out_valid1, culled1, nan1;
    logic signed [15:0] x_min0, x_max0, y_min0, y_max0;
    logic signed [15:0] x_min1, x_max1, y_min1, y_max1;

    int   check_cnt = 0;
    int   error_cnt = 0;
    int   cycle_cnt = 0;
    res_t q0[$];
    res_t q1[$];
    bit   stalled[2];

    bbox_clip_unit #(.COORD_W(16), .SCREEN_W(SW), .SCREEN_H(SH), .TILE_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .triangle(triangle), .out_valid(out_valid0), .out_ready(out_ready),
        .bbox_x_min_int(x_min0), .bbox_x_max_int(x_max0),
        .bbox_y_min_int(y_min0), .bbox_y_max_int(y_max0),
        .culled(culled0), .nan_err(nan0)
    );

    bbox_clip_unit #(.COORD_W(16), .SCREEN_W(SW), .SCREEN_H(SH), .TILE_LOG2(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .triangle(triangle), .out_valid(out_valid1), .out_ready(out_ready),
        .bbox_x_min_int(x_min1), .bbox_x_max_int(x_max1),
        .bbox_y_min_int(y_min1), .bbox_y_max_int(y_max1),
        .culled(culled1), .nan_err(nan1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            error_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic void fp16Model(input logic [15:0] h, output bit is_nan,
                                      output int fl, output int ce);
        int  e;
        real mag;
        real v;
        real f;
        real c;
        e      = int'(h[14:10]);
        is_nan = (e == 31) && (h[9:0] != 10'd0);
        if (e == 31) begin
            fl = h[15] ? -32767 : 32767;
            ce = fl;
        end else begin
            if (e == 0) mag = real'(h[9:0]) * (2.0 ** (-24));
            else        mag = real'(1024 + int'(h[9:0])) * (2.0 ** (e - 25));
            v = h[15] ? -mag : mag;
            f = $floor(v);
            c = $ceil(v);
            if (f > 32767.0)  f = 32767.0;
            if (f < -32767.0) f = -32767.0;
            if (c > 32767.0)  c = 32767.0;
            if (c < -32767.0) c = -32767.0;
            fl = $rtoi(f);
            ce = $rtoi(c);
        end
    endfunction

    function automatic res_t model(input logic [143:0] t, input int tl);
        res_t r;
        int xmn = 32767, xmx = -32767, ymn = 32767, ymx = -32767;
        int fl, ce, mask;
        bit n, nan_seen = 0, empty;
        for (int v = 0; v < 3; v++) begin
            fp16Model(t[143-48*v -: 16], n, fl, ce);
            if (n) nan_seen = 1;
            else begin
                if (fl < xmn) xmn = fl;
                if (ce > xmx) xmx = ce;
            end
            fp16Model(t[127-48*v -: 16], n, fl, ce);
            if (n) nan_seen = 1;
            else begin
                if (fl < ymn) ymn = fl;
                if (ce > ymx) ymx = ce;
            end
        end
        xmn = (xmn < 0) ? 0 : ((xmn > SW) ? SW : xmn);
        ymn = (ymn < 0) ? 0 : ((ymn > SH) ? SH : ymn);
        xmx = (xmx > SW - 1) ? SW - 1 : ((xmx < -1) ? -1 : xmx);
        ymx = (ymx > SH - 1) ? SH - 1 : ((ymx < -1) ? -1 : ymx);
        empty = (xmn > xmx) || (ymn > ymx);
        mask = (1 << tl) - 1;
        xmn = xmn & ~mask;
        ymn = ymn & ~mask;
        xmx = xmx | mask;
        ymx = ymx | mask;
        if (xmx > SW - 1) xmx = SW - 1;
        if (ymx > SH - 1) ymx = SH - 1;
        r.x_min       = 16'(xmn);
        r.x_max       = 16'(xmx);
        r.y_min       = 16'(ymn);
        r.y_max       = 16'(ymx);
        r.culled      = nan_seen || empty;
        r.nan_err     = nan_seen;
        r.accept_edge = 0;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accept edge
    task automatic applyStimulus(input logic [143:0] t, output int acc_edge);
        int   waited = 0;
        bit   ok = 0;
        res_t e0, e1;
        acc_edge = -1;
        in_valid = 1'b1;
        triangle = t;
        while (!ok && waited < 40) begin
            @(negedge clk);
            if (in_ready0 === 1'b1) ok = 1;
            else waited++;
        end
        if (!ok) checkOutput("accept_timeout", 0, 1);
        else begin
            acc_edge       = cycle_cnt + 1;
            e0             = model(t, 0);
            e1             = model(t, 3);
            e0.accept_edge = acc_edge;
            e1.accept_edge = acc_edge;
            q0.push_back(e0);
            q1.push_back(e1);
            checkOutput("accept_sync", in_ready1, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) checkOutput("drain_timeout", q0.size() + q1.size(), 0);
        #1;
    endtask

    task automatic monitorDut(input int d);
        res_t  act;
        res_t  exp_r;
        logic  ov;
        logic  ir;
        string p;
        if (d == 0) begin
            p = "d0"; ov = out_valid0; ir = in_ready0;
            act.x_min = x_min0; act.x_max = x_max0; act.y_min = y_min0; act.y_max = y_max0;
            act.culled = culled0; act.nan_err = nan0;
        end else begin
            p = "d3"; ov = out_valid1; ir = in_ready1;
            act.x_min = x_min1; act.x_max = x_max1; act.y_min = y_min1; act.y_max = y_max1;
            act.culled = culled1; act.nan_err = nan1;
        end
        if (ov !== 1'b1) return;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checkOutput({p, " unexpected_out"}, 1, 0);
            return;
        end
        exp_r = (d == 0) ? q0[0] : q1[0];
        checkOutput({p, " x_min"}, act.x_min, exp_r.x_min);
        checkOutput({p, " x_max"}, act.x_max, exp_r.x_max);
        checkOutput({p, " y_min"}, act.y_min, exp_r.y_min);
        checkOutput({p, " y_max"}, act.y_max, exp_r.y_max);
        checkOutput({p, " culled"}, act.culled, exp_r.culled);
        checkOutput({p, " nan_err"}, act.nan_err, exp_r.nan_err);
        checkOutput({p, " in_ready_busy"}, ir, 0);
        if (out_ready) begin
            if (!stalled[d]) checkOutput({p, " latency"}, cycle_cnt + 1 - exp_r.accept_edge, 8);
            stalled[d] = 0;
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end else begin
            stalled[d] = 1;
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            monitorDut(0);
            monitorDut(1);
        end
    end

    initial begin
        int a0, a1, dummy;
        stalled[0] = 0;
        stalled[1] = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        triangle  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst in_ready", in_ready0, 0);
        checkOutput("rst out_valid", out_valid0, 0);
        checkOutput("rst x_min", x_min0, 0);
        checkOutput("rst y_max", y_max0, 0);
        checkOutput("rst culled", culled0, 0);
        checkOutput("rst nan_err", nan0, 0);
        checkOutput("rst d3 out_valid", out_valid1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst in_ready", in_ready0, 1);
        checkOutput("post_rst d3 in_ready", in_ready1, 1);
        @(posedge clk);
        #1;

        $display("[TB] basic cases and back-to-back throughput");
        applyStimulus(TRI_BASE, a0);
        applyStimulus(TRI_FRAC, a1);
        checkOutput("throughput", a1 - a0, 9);
        waitDrain();
        applyStimulus(TRI_NEGX, dummy);
        applyStimulus(TRI_OFFX, dummy);
        applyStimulus(TRI_NAN, dummy);
        applyStimulus(TRI_WIDE, dummy);
        applyStimulus(TRI_INF, dummy);
        waitDrain();

        $display("[TB] back-pressure with ignored in_valid");
        out_ready = 1'b0;
        applyStimulus(TRI_WIDE, dummy);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            triangle = TRI_BASE;
        end
        checkOutput("stall out_valid", out_valid0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();

        $display("[TB] reset during conversion");
        applyStimulus(TRI_FRAC, dummy);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst in_ready", in_ready0, 0);
        checkOutput("midrst out_valid", out_valid0, 0);
        checkOutput("midrst x_max", x_max0, 0);
        checkOutput("midrst y_min", y_min0, 0);
        checkOutput("midrst d3 x_max", x_max1, 0);
        checkOutput("midrst culled", culled0, 0);
        void'(q0.pop_back());
        void'(q1.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst release in_ready", in_ready0, 1);
        checkOutput("midrst release out_valid", out_valid0, 0);
        @(posedge clk);
        #1;
        applyStimulus(TRI_NAN, dummy);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
